// File: rtl/ad_da_bridge.sv
// Multi-channel ADC->DAC bridge: registered sample path with width conversion,
// selectable output source, and a single-channel capture buffer for readback/playback.
module ad_da_bridge #(
    parameter int NUM_CH = 2,
    parameter int ADC_W  = 12,
    parameter int DAC_W  = 14,
    parameter int BUF_AW = 10,
    parameter int CH_W   = 3
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*ADC_W-1:0]  adc_data,
    input  logic                     adc_valid,
    input  logic [1:0]               mode,
    input  logic [DAC_W-1:0]         dac_const,
    output logic [NUM_CH*DAC_W-1:0]  dac_data,
    output logic                     dac_wrt,
    input  logic                     cap_start,
    input  logic [CH_W-1:0]          cap_ch,
    output logic                     cap_busy,
    output logic                     cap_done,
    input  logic [BUF_AW-1:0]        rd_addr,
    output logic [ADC_W-1:0]         rd_data
);

    localparam int DEPTH = 2**BUF_AW;
    localparam int WIDE  = (DAC_W > ADC_W) ? DAC_W : ADC_W;
    localparam int UP    = (DAC_W >= ADC_W) ? DAC_W - ADC_W : 0;
    localparam int DN    = (DAC_W < ADC_W) ? ADC_W - DAC_W : 0;
    localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_CONST = 2'b01;
    localparam logic [1:0] MODE_PLAY  = 2'b10;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} cap_state_t;

    // Left-justify when widening, keep the MSBs when narrowing.
    function automatic logic [DAC_W-1:0] conv(input logic [ADC_W-1:0] a);
        logic [WIDE-1:0] w;
        w = WIDE'(a);
        w = (w << UP) >> DN;
        return w[DAC_W-1:0];
    endfunction

    logic [NUM_CH*ADC_W-1:0] adc_reg;
    logic                    valid_reg;
    logic [1:0]              mode_reg;
    logic                    done_reg;
    logic [NUM_CH*DAC_W-1:0] dac_next;

    cap_state_t              state_reg, state_next;
    logic [BUF_AW-1:0]       wr_ptr;
    logic [BUF_AW-1:0]       pb_ptr;
    logic [CH_W-1:0]         cap_ch_reg;
    logic [ADC_W-1:0]        pb_rdata;
    logic [ADC_W-1:0]        ch_word [2**CH_W];
    logic [ADC_W-1:0]        mem [DEPTH];
    logic                    start_ok;
    logic                    wr_en;

    // Mode and buffer status travel with the sample so a mid-sample change cannot glitch it.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            adc_reg   <= '0;
            valid_reg <= 1'b0;
            mode_reg  <= MODE_PASS;
            done_reg  <= 1'b0;
        end else begin
            valid_reg <= adc_valid;
            if (adc_valid) begin
                adc_reg  <= adc_data;
                mode_reg <= mode;
                done_reg <= cap_done;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign dac_next[gi*DAC_W +: DAC_W] =
                (mode_reg == MODE_CONST)             ? dac_const :
                (mode_reg == MODE_PLAY && done_reg)  ? conv(pb_rdata) :
                (mode_reg == MODE_PASS)              ? conv(adc_reg[gi*ADC_W +: ADC_W]) :
                                                       MID;
        end
        for (genvar gi = 0; gi < 2**CH_W; gi++) begin : g_word
            if (gi < NUM_CH) begin : g_real
                assign ch_word[gi] = adc_data[gi*ADC_W +: ADC_W];
            end else begin : g_pad
                assign ch_word[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            dac_data <= {NUM_CH{MID}};
            dac_wrt  <= 1'b0;
        end else begin
            dac_wrt <= valid_reg;
            if (valid_reg) begin
                dac_data <= dac_next;
            end
        end
    end

    assign start_ok = cap_start && ({1'b0, cap_ch} < NUM_CH_L) && (state_reg != CAPTURE);
    assign wr_en    = (state_reg == CAPTURE) && adc_valid;
    assign cap_busy = (state_reg == CAPTURE);
    assign cap_done = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start_ok) state_next = CAPTURE;
            CAPTURE:    if (wr_en && (&wr_ptr)) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            wr_ptr     <= '0;
            cap_ch_reg <= '0;
            pb_ptr     <= '0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                wr_ptr     <= '0;
                cap_ch_reg <= cap_ch;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Leaving playback rewinds, so every playback session starts at address 0.
            if (mode != MODE_PLAY) begin
                pb_ptr <= '0;
            end else if (adc_valid) begin
                pb_ptr <= pb_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= ch_word[cap_ch_reg];
        end
    end

    always_ff @(posedge sys_clk) begin
        pb_rdata <= mem[pb_ptr];
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_ad_da_bridge.sv
// Scoreboarded bench for ad_da_bridge: directed vectors push expected DAC words,
// a negedge monitor pops and compares on every dac_wrt.
module tb_ad_da_bridge;
    localparam int NUM_CH = 2;
    localparam int ADC_W  = 12;
    localparam int DAC_W  = 14;
    localparam int BUF_AW = 10;
    localparam int CH_W   = 3;

    logic                    sys_clk;
    logic                    rst_n;
    logic [NUM_CH*ADC_W-1:0] adc_data;
    logic                    adc_valid;
    logic [1:0]              mode;
    logic [DAC_W-1:0]        dac_const;
    logic [NUM_CH*DAC_W-1:0] dac_data;
    logic                    dac_wrt;
    logic                    cap_start;
    logic [CH_W-1:0]         cap_ch;
    logic                    cap_busy;
    logic                    cap_done;
    logic [BUF_AW-1:0]       rd_addr;
    logic [ADC_W-1:0]        rd_data;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int txn_cnt   = 0;
    logic [27:0] exp_q[$];

    ad_da_bridge #(
        .NUM_CH(NUM_CH), .ADC_W(ADC_W), .DAC_W(DAC_W), .BUF_AW(BUF_AW), .CH_W(CH_W)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
        .mode(mode), .dac_const(dac_const), .dac_data(dac_data), .dac_wrt(dac_wrt),
        .cap_start(cap_start), .cap_ch(cap_ch), .cap_busy(cap_busy), .cap_done(cap_done),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [13:0] cv(input logic [11:0] a);
        return {a, 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [11:0] c1, input logic [11:0] c0, input logic [27:0] e);
        adc_data  = {c1, c0};
        adc_valid = 1'b1;
        exp_q.push_back(e);
        tick();
        adc_valid = 1'b0;
    endtask

    always @(negedge sys_clk) begin : monitor
        logic [27:0] e;
        if (rst_n === 1'b1 && dac_wrt === 1'b1) begin
            txn_cnt++;
            if (exp_q.size() == 0) begin
                check("dac_unexpected_wrt", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("dac txn %0d: ch1=%h ch0=%h exp ch1=%h ch0=%h",
                         txn_cnt, dac_data[27:14], dac_data[13:0], e[27:14], e[13:0]);
                check("dac_data", 32'(dac_data), 32'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; mode = 2'b00;
        dac_const = '0; cap_start = 1'b0; cap_ch = '0; rd_addr = '0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_dac_data", 32'(dac_data), 32'({14'h2000, 14'h2000}));
        check("rst_dac_wrt", 32'(dac_wrt), 32'd0);
        check("rst_cap_busy", 32'(cap_busy), 32'd0);
        check("rst_cap_done", 32'(cap_done), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        // Pass-through, then hold on idle, then back-to-back strobes
        send(12'h123, 12'hABC, {14'h048C, 14'h2AF0});
        tick(); tick(); tick(); tick();
        check("idle_dac_wrt", 32'(dac_wrt), 32'd0);
        check("idle_hold", 32'(dac_data), 32'({14'h048C, 14'h2AF0}));
        send(12'h000, 12'hFFF, {14'h0000, 14'h3FFC});
        send(12'h800, 12'h001, {14'h2000, 14'h0004});
        tick(); tick();

        // Out-of-range channel is ignored
        cap_ch = 3'd2; cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        tick();
        check("badch_busy", 32'(cap_busy), 32'd0);
        check("badch_done", 32'(cap_done), 32'd0);

        // Capture ch1; the strobe coincident with cap_start must not be stored
        cap_ch = 3'd1; cap_start = 1'b1;
        send(12'hFFF, 12'h555, {cv(12'hFFF), cv(12'h555)});
        cap_start = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            if (i == 10) begin
                cap_ch = 3'd0; cap_start = 1'b1;
            end
            send(12'(i), 12'h555, {cv(12'(i)), cv(12'h555)});
            cap_start = 1'b0;
            if (i == 0) check("cap_busy_start", 32'(cap_busy), 32'd1);
            if (i == 1022) check("cap_busy_before_last", 32'(cap_busy), 32'd1);
        end
        check("cap_done_after_1024", 32'(cap_done), 32'd1);
        check("cap_busy_after_1024", 32'(cap_busy), 32'd0);

        // Readback
        rd_addr = 10'd5;    tick(); check("rd_5", 32'(rd_data), 32'd5);
        rd_addr = 10'd0;    tick(); check("rd_0", 32'(rd_data), 32'd0);
        rd_addr = 10'd512;  tick(); check("rd_512", 32'(rd_data), 32'd512);
        rd_addr = 10'd1023; tick(); check("rd_1023", 32'(rd_data), 32'd1023);

        // Playback with wrap
        mode = 2'b10;
        tick();
        for (int i = 0; i < 1028; i++) begin
            send(12'h777, 12'h999, {cv(12'(i % 1024)), cv(12'(i % 1024))});
        end
        tick(); tick();

        // Constant and mute
        mode = 2'b01; dac_const = 14'h1FFF;
        send(12'h321, 12'h654, {14'h1FFF, 14'h1FFF});
        mode = 2'b11;
        send(12'h321, 12'h654, {14'h2000, 14'h2000});
        tick(); tick();

        // Reset in the middle of a capture
        mode = 2'b00; cap_ch = 3'd0; cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        send(12'h010, 12'h020, {cv(12'h010), cv(12'h020)});
        send(12'h011, 12'h021, {cv(12'h011), cv(12'h021)});
        check("midcap_busy", 32'(cap_busy), 32'd1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(cap_busy), 32'd0);
        check("midrst_done", 32'(cap_done), 32'd0);
        check("midrst_dac", 32'(dac_data), 32'({14'h2000, 14'h2000}));

        // Playback without a valid buffer outputs midscale
        mode = 2'b10;
        tick();
        send(12'hABC, 12'h123, {14'h2000, 14'h2000});
        tick(); tick(); tick(); tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
